sram_bank_responder: RTL and testbench



---
 rtl/sram_bank_responder.sv | 72 +++++++
 tb/tb_sram_bank_responder.sv | 99 +++++++++
 2 files changed

// File: rtl/sram_bank_responder.sv
// sram_bank_responder: dual-set byte-masked SRAM bank that self-clears after reset, then serves registered reads.
module sram_bank_responder #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [ADDR_W-1:0] sram_raddr,
  output logic [31:0]       sram_rdata,
  output logic [31:0]       sram_rdata_1,
  input  logic              sram_write_enable,
  input  logic [3:0]        sram_bytemask,
  input  logic [ADDR_W-1:0] sram_waddr,
  input  logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_wdata_1,
  output logic              init_done,
  output logic [15:0]       wr_count
);
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0] rdata_q, rdata_d, rdata_1_q, rdata_1_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] mem0 [DEPTH];
  logic [31:0] mem1 [DEPTH];
  logic wr_ok, rd_ok;
  assign wr_ok = state_q == READY && !sram_write_enable && sram_bytemask != 4'hF
                 && {1'b0, sram_waddr} < DEPTH_W;
  assign rd_ok = state_q == READY && {1'b0, sram_raddr} < DEPTH_W;
  always_comb begin
    state_d   = (state_q == CLEAR && ptr_q == LAST) ? READY : state_q;
    ptr_d     = state_q == CLEAR ? ptr_q + 1'b1 : ptr_q;
    cnt_d     = (wr_ok && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    rdata_d   = rd_ok ? mem0[sram_raddr] : 32'd0;
    rdata_1_d = rd_ok ? mem1[sram_raddr] : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rdata_1_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rdata_1_q <= rdata_1_d;
    end
  end
  // Storage has no reset; the CLEAR sweep zeroes it before any read is served.
  always_ff @(posedge clk) begin
    if (!srst && state_q == CLEAR) begin
      mem0[ptr_q] <= '0;
      mem1[ptr_q] <= '0;
    end else if (!srst && wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (!sram_bytemask[i]) begin
          mem0[sram_waddr][8*i +: 8] <= sram_wdata;
          mem1[sram_waddr][8*i +: 8] <= sram_wdata_1;
        end
      end
    end
  end
  assign sram_rdata   = rdata_q;
  assign sram_rdata_1 = rdata_1_q;
  assign init_done    = state_q == READY;
  assign wr_count     = cnt_q;
endmodule

// File: tb/tb_sram_bank_responder.sv
// tb_sram_bank_responder: directed checks of clear sequencing, masked writes, read-first and saturation.
module tb_sram_bank_responder;
  localparam int DEPTH = 16, ADDR_W = 5;
  logic clk = 0, srst = 1;
  logic [ADDR_W-1:0] raddr = '0, waddr = '0;
  logic [31:0] rdata, rdata_1;
  logic we = 1;
  logic [3:0] mask = 4'hF;
  logic [7:0] wd = '0, wd1 = '0;
  logic done;
  logic [15:0] cnt;
  int n = 0, fails = 0;
  sram_bank_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .srst(srst), .sram_raddr(raddr), .sram_rdata(rdata), .sram_rdata_1(rdata_1),
    .sram_write_enable(we), .sram_bytemask(mask), .sram_waddr(waddr), .sram_wdata(wd),
    .sram_wdata_1(wd1), .init_done(done), .wr_count(cnt));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [3:0] m, input logic [7:0] d0, input logic [7:0] d1);
    waddr = a; mask = m; wd = d0; wd1 = d1; we = 0;
    tick();
    we = 1; mask = 4'hF;
  endtask
  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] e0, input logic [31:0] e1, input string tag);
    raddr = a;
    tick();
    chk({tag, "_set0"}, rdata, e0);
    chk({tag, "_set1"}, rdata_1, e1);
  endtask
  initial begin
    tick(); tick();
    chk("rst_rdata", rdata, 0);
    chk("rst_rdata_1", rdata_1, 0);
    chk("rst_init_done", {31'd0, done}, 0);
    chk("rst_wr_count", {16'd0, cnt}, 0);
    srst = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 1) begin waddr = 2; mask = 4'h0; wd = 8'hFF; wd1 = 8'hFF; we = 0; end
      if (k == 10) begin we = 1; mask = 4'hF; end
      tick();
      chk($sformatf("clear_done_edge%0d", k), {31'd0, done}, {31'd0, k >= DEPTH});
    end
    chk("clear_write_not_counted", {16'd0, cnt}, 0);
    for (int a = 0; a < DEPTH; a++) rd(a[ADDR_W-1:0], 0, 0, $sformatf("cleared_%0d", a));
    wr(5, 4'b1110, 8'hAA, 8'h55);
    wr(5, 4'b0111, 8'h11, 8'h22);
    rd(5, 32'h110000AA, 32'h22000055, "lane_write");
    chk("lane_count", {16'd0, cnt}, 2);
    wr(3, 4'h0, 8'hAA, 8'h33);
    raddr = 3; waddr = 3; mask = 4'h0; wd = 8'h5C; wd1 = 8'hC5; we = 0;
    tick();
    we = 1; mask = 4'hF;
    chk("rdw_old_set0", rdata, 32'hAAAAAAAA);
    chk("rdw_old_set1", rdata_1, 32'h33333333);
    tick();
    chk("rdw_new_set0", rdata, 32'h5C5C5C5C);
    chk("rdw_new_set1", rdata_1, 32'hC5C5C5C5);
    chk("rdw_count", {16'd0, cnt}, 4);
    wr(4, 4'hF, 8'h77, 8'h77);
    wr(5'(DEPTH), 4'h0, 8'h77, 8'h77);
    chk("ignored_count", {16'd0, cnt}, 4);
    rd(4, 0, 0, "nop_mask");
    rd(5'(DEPTH), 0, 0, "oob_read");
    rd(5, 32'h110000AA, 32'h22000055, "unchanged_5");
    wr(7, 4'h0, 8'hFF, 8'hFF);
    rd(7, 32'hFFFFFFFF, 32'hFFFFFFFF, "pre_reset_7");
    srst = 1;
    tick();
    srst = 0;
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_count", {16'd0, cnt}, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      chk($sformatf("reclear_done_edge%0d", k), {31'd0, done}, {31'd0, k >= DEPTH});
    end
    rd(7, 0, 0, "post_reset_7");
    rd(5, 0, 0, "post_reset_5");
    waddr = 1; mask = 4'h0; wd = 8'h01; wd1 = 8'h02; we = 0;
    for (int k = 0; k < 65535; k++) tick();
    chk("sat_reach", {16'd0, cnt}, 32'hFFFF);
    tick();
    chk("sat_65536", {16'd0, cnt}, 32'hFFFF);
    tick();
    we = 1; mask = 4'hF;
    chk("sat_hold", {16'd0, cnt}, 32'hFFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
